parity_checker: RTL and testbench



---
 rtl/parity_checker.sv | 99 +++++++++
 tb/tb_parity_checker.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_checker.sv
// Serial even-parity frame checker: collects DATA_BITS data bits (MSB first) plus a
// parity bit, reports the nibble and parity status, and counts parity failures.
module parity_checker #(
    parameter int DATA_BITS = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic                 in_bit,
    input  logic                 clear_cnt,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 parity_err,
    output logic                 frame_abort,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [BC_W-1:0] LAST_DATA = BC_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t               state, state_nx;
    logic [DATA_BITS-1:0] sreg, sreg_nx;
    logic [BC_W-1:0]      bit_cnt, bit_cnt_nx;
    logic [DATA_BITS:0]   shifted;
    logic                 load_out;
    logic                 err_nx;
    logic                 abort_nx;

    assign shifted = {sreg, in_bit};

    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        bit_cnt_nx = bit_cnt;
        load_out   = 1'b0;
        abort_nx   = 1'b0;
        err_nx     = (^sreg) ^ in_bit;
        if (in_valid) begin
            if (in_sof) begin
                // A start of frame always restarts collection; mid-frame it also discards.
                abort_nx   = (state != IDLE);
                sreg_nx    = DATA_BITS'(in_bit);
                bit_cnt_nx = BC_W'(1);
                state_nx   = (DATA_BITS == 1) ? PARITY : DATA;
            end else begin
                case (state)
                    IDLE: ;
                    DATA: begin
                        sreg_nx    = shifted[DATA_BITS-1:0];
                        bit_cnt_nx = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_DATA) state_nx = PARITY;
                    end
                    PARITY: begin
                        load_out   = 1'b1;
                        bit_cnt_nx = '0;
                        state_nx   = IDLE;
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            parity_err  <= 1'b0;
            frame_abort <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nx;
            sreg        <= sreg_nx;
            bit_cnt     <= bit_cnt_nx;
            out_valid   <= load_out;
            frame_abort <= abort_nx;
            if (load_out) begin
                out_data   <= sreg;
                parity_err <= err_nx;
            end
            if (clear_cnt)
                err_count <= '0;
            else if (load_out && err_nx && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_checker.sv
// Self-checking bench for parity_checker: directed scenarios plus randomized traffic
// compared against a frame-level reference model.
module tb_parity_checker;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_sof, in_bit, clear_cnt;
    logic       out_valid, parity_err, frame_abort;
    logic [3:0] out_data;
    logic [7:0] err_count;
    logic       out_valid2, parity_err2, frame_abort2;
    logic [3:0] out_data2;
    logic [1:0] err_count2;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    // reference model state
    bit         m_bits[$];
    bit         m_in_frame;
    logic       exp_valid, exp_err, exp_abort;
    logic [3:0] exp_data;
    int         exp_cnt8, exp_cnt2;

    parity_checker #(.DATA_BITS(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
        .clear_cnt(clear_cnt), .out_valid(out_valid), .out_data(out_data),
        .parity_err(parity_err), .frame_abort(frame_abort), .err_count(err_count)
    );

    parity_checker #(.DATA_BITS(4), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
        .clear_cnt(clear_cnt), .out_valid(out_valid2), .out_data(out_data2),
        .parity_err(parity_err2), .frame_abort(frame_abort2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_bits.delete();
        m_in_frame = 1'b0;
        exp_valid = 1'b0; exp_err = 1'b0; exp_abort = 1'b0; exp_data = 4'd0;
        exp_cnt8 = 0; exp_cnt2 = 0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic b, input logic clr);
        logic [3:0] d;
        bit         par;
        exp_valid = 1'b0;
        exp_abort = 1'b0;
        if (v) begin
            if (s) begin
                if (m_in_frame) exp_abort = 1'b1;
                m_bits.delete();
                m_bits.push_back(b);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                if (m_bits.size() < 4) begin
                    m_bits.push_back(b);
                end else begin
                    d = 4'd0;
                    par = b;
                    foreach (m_bits[i]) begin
                        d = {d[2:0], m_bits[i]};
                        par = par ^ m_bits[i];
                    end
                    exp_valid = 1'b1;
                    exp_data = d;
                    exp_err = par;
                    if (par) begin
                        if (exp_cnt8 < 255) exp_cnt8++;
                        if (exp_cnt2 < 3) exp_cnt2++;
                    end
                    m_in_frame = 1'b0;
                    m_bits.delete();
                end
            end
        end
        if (clr) begin
            exp_cnt8 = 0;
            exp_cnt2 = 0;
        end
    endtask

    task automatic step(input logic v, input logic s, input logic b, input logic clr);
        in_valid = v; in_sof = s; in_bit = b; clear_cnt = clr;
        @(posedge clk);
        #1;
        model_step(v, s, b, clr);
        in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0; clear_cnt = 1'b0;
    endtask

    // all bits except parity; the caller issues the parity step to check right after it
    task automatic send_data(input logic [3:0] d);
        for (int unsigned i = 0; i < 4; i++) step(1'b1, i == 0, d[3-i], 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0; clear_cnt = 1'b0;
        model_reset();
        #12;
        total_cnt++;
        if ({out_valid, out_data, parity_err, frame_abort, err_count, err_count2} !== 17'd0)
            $display("FAIL reset_values: got %h required 0",
                     {out_valid, out_data, parity_err, frame_abort, err_count, err_count2});
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        send_data(4'b1011);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        total_cnt++;
        if ({out_valid, out_data, parity_err, err_count} !== {1'b1, 4'b1011, 1'b0, 8'd0})
            $display("FAIL good_frame: got %h required %h",
                     {out_valid, out_data, parity_err, err_count}, {1'b1, 4'b1011, 1'b0, 8'd0});
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({out_valid, out_data, parity_err} !== {1'b0, 4'b1011, 1'b0})
            $display("FAIL good_frame_hold: got %h required %h",
                     {out_valid, out_data, parity_err}, {1'b0, 4'b1011, 1'b0});
        else pass_cnt++;
    endtask

    task automatic test_bad_frame();
        send_data(4'b1011);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({out_valid, out_data, parity_err, err_count} !== {1'b1, 4'b1011, 1'b1, 8'd1})
            $display("FAIL bad_frame: got %h required %h",
                     {out_valid, out_data, parity_err, err_count}, {1'b1, 4'b1011, 1'b1, 8'd1});
        else pass_cnt++;
        send_data(4'b0000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({out_valid, out_data, parity_err, err_count} !== {1'b1, 4'b0000, 1'b0, 8'd1})
            $display("FAIL good_after_bad: got %h required %h",
                     {out_valid, out_data, parity_err, err_count}, {1'b1, 4'b0000, 1'b0, 8'd1});
        else pass_cnt++;
    endtask

    task automatic test_abort();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total_cnt++;
        if ({frame_abort, out_valid, out_data, parity_err} !== {1'b1, 1'b0, 4'b0000, 1'b0})
            $display("FAIL abort_pulse: got %h required %h",
                     {frame_abort, out_valid, out_data, parity_err}, {1'b1, 1'b0, 4'b0000, 1'b0});
        else pass_cnt++;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({out_valid, out_data, parity_err, frame_abort} !== {1'b1, 4'b0110, 1'b0, 1'b0})
            $display("FAIL abort_restart: got %h required %h",
                     {out_valid, out_data, parity_err, frame_abort}, {1'b1, 4'b0110, 1'b0, 1'b0});
        else pass_cnt++;
    endtask

    task automatic test_gaps();
        logic [4:0] frame;
        int unsigned spurious;
        frame = 5'b11000;
        spurious = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            if (out_valid || frame_abort) spurious++;
        end
        for (int unsigned i = 0; i < 5; i++) begin
            step(1'b1, i == 0, frame[4-i], 1'b0);
            if (i < 4) begin
                if (out_valid || frame_abort) spurious++;
                for (int unsigned g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 1'b0, 1'b0);
                    if (out_valid || frame_abort) spurious++;
                end
            end
        end
        total_cnt++;
        if ({out_valid, out_data, parity_err, err_count} !== {1'b1, 4'b1100, 1'b0, 8'd1})
            $display("FAIL gap_frame: got %h required %h",
                     {out_valid, out_data, parity_err, err_count}, {1'b1, 4'b1100, 1'b0, 8'd1});
        else pass_cnt++;
        total_cnt++;
        if (spurious != 0) $display("FAIL gap_spurious: got %0d pulses required 0", spurious);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        send_data(4'b0101);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({out_valid, out_data, parity_err} !== {1'b1, 4'b0101, 1'b0})
            $display("FAIL b2b_first: got %h required %h",
                     {out_valid, out_data, parity_err}, {1'b1, 4'b0101, 1'b0});
        else pass_cnt++;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if ({out_valid, frame_abort} !== 2'b00)
            $display("FAIL b2b_sof: got %b required 00", {out_valid, frame_abort});
        else pass_cnt++;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        total_cnt++;
        if ({out_valid, out_data, parity_err} !== {1'b1, 4'b1001, 1'b1})
            $display("FAIL b2b_second: got %h required %h",
                     {out_valid, out_data, parity_err}, {1'b1, 4'b1001, 1'b1});
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [1:0] want2 [5];
        logic [3:0] d;
        want2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total_cnt++;
        if ({err_count, err_count2} !== 10'd0)
            $display("FAIL clear_cnt: got %h required 0", {err_count, err_count2});
        else pass_cnt++;
        for (int unsigned k = 0; k < 5; k++) begin
            d = 4'($urandom);
            send_data(d);
            step(1'b1, 1'b0, ~(^d), 1'b0);
            total_cnt++;
            if ({parity_err2, err_count2, err_count} !== {1'b1, want2[k], 8'(k + 1)})
                $display("FAIL saturate_%0d: got %h required %h", k,
                         {parity_err2, err_count2, err_count}, {1'b1, want2[k], 8'(k + 1)});
            else pass_cnt++;
        end
        d = 4'($urandom);
        send_data(d);
        step(1'b1, 1'b0, ~(^d), 1'b1);
        total_cnt++;
        if ({out_valid, parity_err, err_count2, err_count} !== {1'b1, 1'b1, 2'd0, 8'd0})
            $display("FAIL clear_wins: got %h required %h",
                     {out_valid, parity_err, err_count2, err_count}, {1'b1, 1'b1, 2'd0, 8'd0});
        else pass_cnt++;
    endtask

    task automatic test_midframe_reset();
        int unsigned spurious;
        spurious = 0;
        send_data(4'b1111);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total_cnt++;
        if ({out_valid, out_data, parity_err, frame_abort, err_count, err_count2} !== 17'd0)
            $display("FAIL async_reset: got %h required 0",
                     {out_valid, out_data, parity_err, frame_abort, err_count, err_count2});
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            if (out_valid || frame_abort) spurious++;
        end
        total_cnt++;
        if (spurious != 0 || out_data !== 4'd0)
            $display("FAIL reset_partial: got %0d pulses data %h required 0 pulses data 0",
                     spurious, out_data);
        else pass_cnt++;
        send_data(4'b1010);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({out_valid, out_data, parity_err, err_count} !== {1'b1, 4'b1010, 1'b0, 8'd0})
            $display("FAIL reset_recover: got %h required %h",
                     {out_valid, out_data, parity_err, err_count}, {1'b1, 4'b1010, 1'b0, 8'd0});
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic v, s, b, c;
        for (int unsigned n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 5) == 0);
            b = 1'($urandom);
            c = ($urandom_range(0, 49) == 0);
            step(v, s, b, c);
            total_cnt++;
            if ({out_valid, out_data, parity_err, frame_abort, err_count,
                 out_valid2, out_data2, parity_err2, frame_abort2, err_count2} !==
                {exp_valid, exp_data, exp_err, exp_abort, 8'(exp_cnt8),
                 exp_valid, exp_data, exp_err, exp_abort, 2'(exp_cnt2)})
                $display("FAIL random_%0d: got %h required %h", n,
                         {out_valid, out_data, parity_err, frame_abort, err_count,
                          out_valid2, out_data2, parity_err2, frame_abort2, err_count2},
                         {exp_valid, exp_data, exp_err, exp_abort, 8'(exp_cnt8),
                          exp_valid, exp_data, exp_err, exp_abort, 2'(exp_cnt2)});
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_abort();
        test_gaps();
        test_back_to_back();
        test_saturation();
        test_midframe_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
